p_ssync_nchan_filt: RTL and testbench

Parametrised multi-channel synchroniser: the next generation of the fixed 3-stage single-bit synchroniser cells in vlibs. Each of WIDTH independent asynchronous inputs passes through a DEPTH-flop synchronising chain into the `clk` domain. An optional per-channel stability filter suppresses pulses shorter than FILT_CYC cycles. Optional edge-detect outputs are compiled in by macro. It sits at clock-domain boundaries for quasi-static control and status signals: interrupts, straps, power/idle flags.

---
 rtl/p_ssync_nchan_filt.sv | 117 +++++++++++
 tb/tb_p_ssync_nchan_filt.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/p_ssync_nchan_filt.sv
// WIDTH-channel DEPTH-flop synchroniser with an optional per-channel stability filter (FILT_CYC > 0).
// Define P_SSYNC_EDGE_DET_EN to add the registered copy of q and the rise/fall pulse outputs.
module p_ssync_nchan_filt #(
  parameter int               WIDTH    = 1,
  parameter int               DEPTH    = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = '1,
  parameter int               FILT_CYC = 0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef P_SSYNC_EDGE_DET_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  if (DEPTH < 2) begin : g_chk_depth
    $error("p_ssync_nchan_filt: DEPTH must be at least 2");
  end
  if (WIDTH < 1) begin : g_chk_width
    $error("p_ssync_nchan_filt: WIDTH must be at least 1");
  end
  if (FILT_CYC > 255) begin : g_chk_filt
    $error("p_ssync_nchan_filt: FILT_CYC must not exceed 255");
  end

  logic [WIDTH-1:0] st_q [DEPTH];
  logic [WIDTH-1:0] st_d [DEPTH];
  logic [WIDTH-1:0] s;

  always_comb begin
    st_d[0] = d;
    for (int k = 1; k < DEPTH; k++) begin
      st_d[k] = st_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int k = 0; k < DEPTH; k++) begin
        st_q[k] <= RST_VAL;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign s = st_q[DEPTH-1];

  if (FILT_CYC == 0) begin : g_nofilt
    assign q = s;
  end else begin : g_filt
    localparam int             CW       = $clog2(FILT_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_CYC - 1);

    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Any cycle where s agrees with the filtered level restarts that channel's window.
    always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = '0;
        if (s[i] != filt_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            filt_d[i] = s[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        filt_q <= RST_VAL;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        filt_q <= filt_d;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end

    assign q = filt_q;
  end

`ifdef P_SSYNC_EDGE_DET_EN
  // Previous-cycle copy of q; shares RST_VAL with q so reset itself never looks like an edge.
  logic [WIDTH-1:0] q_prev_q;
  logic [WIDTH-1:0] q_prev_d;

  assign q_prev_d = q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      q_prev_q <= RST_VAL;
    end else begin
      q_prev_q <= q_prev_d;
    end
  end

  assign rise = q & ~q_prev_q;
  assign fall = ~q & q_prev_q;
`endif

endmodule

// File: tb/tb_p_ssync_nchan_filt.sv
// Directed bench for p_ssync_nchan_filt: default, 8-bit RST_VAL and 4-bit filtered instances share one clock and reset.
module tb_p_ssync_nchan_filt;

  logic       clk = 1'b0;
  logic       rst_;
  logic       d0;
  logic [7:0] d1;
  logic [3:0] d2;
  logic       q0;
  logic [7:0] q1;
  logic [3:0] q2;
`ifdef P_SSYNC_EDGE_DET_EN
  logic       r0, f0;
  logic [7:0] r1, f1;
  logic [3:0] r2, f2;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  p_ssync_nchan_filt u_dflt (
    .clk  (clk),
    .rst_ (rst_),
    .d    (d0),
    .q    (q0)
`ifdef P_SSYNC_EDGE_DET_EN
    ,
    .rise (r0),
    .fall (f0)
`endif
  );

  p_ssync_nchan_filt #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5), .FILT_CYC(0)) u_w8 (
    .clk  (clk),
    .rst_ (rst_),
    .d    (d1),
    .q    (q1)
`ifdef P_SSYNC_EDGE_DET_EN
    ,
    .rise (r1),
    .fall (f1)
`endif
  );

  p_ssync_nchan_filt #(.WIDTH(4), .DEPTH(2), .RST_VAL(4'h0), .FILT_CYC(4)) u_filt (
    .clk  (clk),
    .rst_ (rst_),
    .d    (d2),
    .q    (q2)
`ifdef P_SSYNC_EDGE_DET_EN
    ,
    .rise (r2),
    .fall (f2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp4;
    logic [3:0] prev4;

    rst_ = 1'b0;
    d0   = 1'b1;
    d1   = 8'h5A;
    d2   = 4'h0;
    repeat (3) tick();
    check("rst_q0", 64'(q0), 64'h1);
    check("rst_q1", 64'(q1), 64'hA5);
    check("rst_q2", 64'(q2), 64'h0);
`ifdef P_SSYNC_EDGE_DET_EN
    check("rst_rise1", 64'(r1), 64'h0);
    check("rst_fall1", 64'(f1), 64'h0);
`endif

    // Release with d1 already differing from RST_VAL: three edges to reach q1.
    rst_ = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check("rel_q1", 64'(q1), (t >= 3) ? 64'h5A : 64'hA5);
`ifdef P_SSYNC_EDGE_DET_EN
      check("rel_rise1", 64'(r1), (t == 3) ? 64'h5A : 64'h0);
      check("rel_fall1", 64'(f1), (t == 3) ? 64'hA5 : 64'h0);
`endif
    end

    // Default instance, 1 -> 0 arrives after exactly DEPTH edges.
    d0 = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check("lat_q0", 64'(q0), (t >= 3) ? 64'h0 : 64'h1);
`ifdef P_SSYNC_EDGE_DET_EN
      check("lat_fall0", 64'(f0), (t == 3) ? 64'h1 : 64'h0);
      check("lat_rise0", 64'(r0), 64'h0);
`endif
    end

    // Filtered instance: DEPTH 2 + FILT_CYC 4 = rise at edge 6.
    d2[0] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      check("filt_rise_q2", 64'(q2), (t >= 6) ? 64'h1 : 64'h0);
`ifdef P_SSYNC_EDGE_DET_EN
      check("filt_rise_r2", 64'(r2), (t == 6) ? 64'h1 : 64'h0);
`endif
    end
    d2[0] = 1'b0;
    repeat (7) tick();
    check("filt_back_q2", 64'(q2), 64'h0);

    // Three-cycle pulse is shorter than the window and must not appear.
    d2[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 3) d2[0] = 1'b0;
      check("pulse_q2", 64'(q2), 64'h0);
`ifdef P_SSYNC_EDGE_DET_EN
      check("pulse_r2", 64'(r2), 64'h0);
`endif
    end

    // Differs 3, equal 1, differs 4: window restarts, q changes at edge 10.
    d2[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 3) d2[0] = 1'b0;
      if (t == 4) d2[0] = 1'b1;
      check("restart_q2", 64'(q2), (t >= 10) ? 64'h1 : 64'h0);
    end

    // Mid-window (cnt=2) asynchronous reset between edges.
    d2[0] = 1'b0;
    repeat (4) tick();
    check("pre_arst_q2", 64'(q2), 64'h1);
    #2;
    rst_ = 1'b0;
    #1;
    check("arst_q2", 64'(q2), 64'h0);
    check("arst_q1", 64'(q1), 64'hA5);
`ifdef P_SSYNC_EDGE_DET_EN
    check("arst_r2", 64'(r2), 64'h0);
    check("arst_f2", 64'(f2), 64'h0);
`endif
    tick();
    rst_  = 1'b1;
    d2[0] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      check("post_arst_q2", 64'(q2), (t >= 6) ? 64'h1 : 64'h0);
    end

    // Channels toggled on different cycles each land six edges after their own change.
    prev4 = 4'b0001;
    d2[1] = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      tick();
      exp4 = {t >= 8, t >= 7, t >= 6, t < 9};
      check("indep_q2", 64'(q2), 64'(exp4));
`ifdef P_SSYNC_EDGE_DET_EN
      check("indep_r2", 64'(r2), 64'(exp4 & ~prev4));
      check("indep_f2", 64'(f2), 64'(~exp4 & prev4));
      check("indep_excl2", 64'(r2 & f2), 64'h0);
`endif
      prev4 = exp4;
      if (t == 1) d2[2] = 1'b1;
      if (t == 2) d2[3] = 1'b1;
      if (t == 3) d2[0] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
